// File: rtl/div_unit_if.sv
// Divider request/response bundle between the execute stage and div_unit.
interface div_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            start_i;
  logic [1:0]      op_i;
  logic [XLEN-1:0] rs1_data_i;
  logic [XLEN-1:0] rs2_data_i;
  logic [4:0]      rd_addr_i;
  logic            flush_i;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;
  logic [4:0]      rd_addr_o;

  modport master (
    output start_i, op_i, rs1_data_i, rs2_data_i, rd_addr_i, flush_i,
    input  busy_o, done_o, result_o, rd_addr_o
  );

  modport slave (
    input  start_i, op_i, rs1_data_i, rs2_data_i, rd_addr_i, flush_i,
    output busy_o, done_o, result_o, rd_addr_o
  );
endinterface

// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU): restoring division on operand
// magnitudes, one quotient bit per cycle, sign correction in a final FIX cycle.
module div_unit #(
  parameter int unsigned XLEN = 32
) (
  input logic       clk,
  input logic       rst,
  div_unit_if.slave bus
);
  localparam int unsigned CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] dvd, dvs, quot, rem;
  logic [1:0]      op_q;
  logic            neg_q, neg_r;
  logic [4:0]      rd_q;
  logic            busy, done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  // Accept-cycle decode
  logic            signed_op, a_neg, b_neg, div_zero, ovf, special;
  logic [XLEN-1:0] a_mag, b_mag, special_res;
  // Iteration datapath
  logic [XLEN:0]   part;
  logic            ge;
  logic [XLEN-1:0] diff;
  // Final sign fix
  logic [XLEN-1:0] q_fix, r_fix, fix_res;

  assign signed_op   = ~bus.op_i[0];
  assign a_neg       = signed_op & bus.rs1_data_i[XLEN-1];
  assign b_neg       = signed_op & bus.rs2_data_i[XLEN-1];
  assign a_mag       = a_neg ? -bus.rs1_data_i : bus.rs1_data_i;
  assign b_mag       = b_neg ? -bus.rs2_data_i : bus.rs2_data_i;
  assign div_zero    = (bus.rs2_data_i == '0);
  assign ovf         = signed_op && (bus.rs1_data_i == {1'b1, {(XLEN-1){1'b0}}})
                       && (bus.rs2_data_i == '1);
  assign special     = div_zero | ovf;
  // Divide-by-zero: quotient all ones, remainder = dividend.
  // Signed overflow: quotient = dividend (most negative), remainder 0.
  assign special_res = div_zero ? (bus.op_i[1] ? bus.rs1_data_i : '1)
                                : (bus.op_i[1] ? '0 : bus.rs1_data_i);

  // Partial remainder keeps XLEN+1 bits so the compare never truncates; since
  // rem < dvs always holds, the difference fits back into XLEN bits.
  assign part = {rem, dvd[XLEN-1]};
  assign ge   = (part >= {1'b0, dvs});
  assign diff = part[XLEN-1:0] - dvs;

  assign q_fix   = neg_q ? -quot : quot;
  assign r_fix   = neg_r ? -rem : rem;
  assign fix_res = op_q[1] ? r_fix : q_fix;

  assign bus.busy_o    = busy;
  assign bus.done_o    = done;
  assign bus.result_o  = result;
  assign bus.rd_addr_o = rd_out;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; flush aborts from any state
  always_comb begin
    state_next = state;
    if (bus.flush_i) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE: if (bus.start_i) state_next = special ? DONE : CALC;
        CALC: if (cnt == '0)   state_next = FIX;
        FIX:                   state_next = DONE;
        DONE:                  state_next = IDLE;
        default:               state_next = IDLE;
      endcase
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      dvd    <= '0;
      dvs    <= '0;
      quot   <= '0;
      rem    <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      rd_q   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      rd_out <= '0;
    end else begin
      busy <= (state_next != IDLE);
      done <= (state_next == DONE);
      unique case (state)
        IDLE: begin
          if (bus.start_i && !bus.flush_i) begin
            op_q  <= bus.op_i;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            dvd   <= a_mag;
            dvs   <= b_mag;
            quot  <= '0;
            rem   <= '0;
            cnt   <= CW'(XLEN-1);
            rd_q  <= bus.rd_addr_i;
            if (special) begin
              result <= special_res;
              rd_out <= bus.rd_addr_i;
            end
          end
        end
        CALC: begin
          dvd  <= dvd << 1;
          rem  <= ge ? diff : part[XLEN-1:0];
          quot <= {quot[XLEN-2:0], ge};
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        FIX: begin
          // Outputs only change on completion, so a flush here keeps the old result
          if (!bus.flush_i) begin
            result <= fix_res;
            rd_out <= rd_q;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// Directed and random checks of div_unit with a result scoreboard.
module tb_div_unit;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  logic [36:0] scb[$];

  always #5 clk = ~clk;

  div_unit_if #(.XLEN(32)) bus ();
  div_unit #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : a;
      return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return op[1] ? a % b : a / b;
  endfunction

  // Drives a request at the current negedge; returns at the negedge of cycle 1.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input bit push);
    bus.start_i    = 1'b1;
    bus.op_i       = op;
    bus.rs1_data_i = a;
    bus.rs2_data_i = b;
    bus.rd_addr_i  = rd;
    if (push) scb.push_back({rd, exp});
    @(negedge clk);
    bus.start_i = 1'b0;
    check("busy_c1", bus.busy_o, 1'b1);
  endtask

  // Waits (bounded) for done_o, checks latency and scoreboard head, then steps
  // to the first IDLE cycle and checks the pulse ended.
  task automatic wait_done(input string tag, input int n0, input int exp_lat);
    int n;
    logic [36:0] e;
    n = n0;
    while (bus.done_o !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_sb"}, scb.size(), 1);
    if (scb.size() > 0) begin
      e = scb.pop_front();
      check({tag, "_res"}, bus.result_o, e[31:0]);
      check({tag, "_rd"}, bus.rd_addr_o, e[36:32]);
    end
    @(negedge clk);
    check({tag, "_done_pulse"}, bus.done_o, 1'b0);
    check({tag, "_busy_end"}, bus.busy_o, 1'b0);
  endtask

  initial begin
    int dn;
    logic [1:0]  rop;
    logic [31:0] ra, rb, rexp;
    int rlat;

    rst = 1'b1;
    bus.start_i = 1'b0; bus.op_i = '0; bus.rs1_data_i = '0; bus.rs2_data_i = '0;
    bus.rd_addr_i = '0; bus.flush_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy_o, 1'b0);
    check("rst_done", bus.done_o, 1'b0);
    check("rst_res", bus.result_o, 32'd0);
    check("rst_rd", bus.rd_addr_o, 5'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic signed division and remainder, back-to-back
    start_op(2'b00, 32'd100, 32'd7, 5'd1, 32'd14, 1'b1); wait_done("div_100_7", 1, 34);
    start_op(2'b10, 32'd100, 32'd7, 5'd2, 32'd2, 1'b1);  wait_done("rem_100_7", 1, 34);

    // Sign handling
    start_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 1'b1); wait_done("div_m7_2", 1, 34);
    start_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 1'b1); wait_done("rem_m7_2", 1, 34);
    start_op(2'b00, 32'd7, 32'hFFFF_FFFE, 5'd7, 32'hFFFF_FFFD, 1'b1); wait_done("div_7_m2", 1, 34);
    start_op(2'b10, 32'd7, 32'hFFFF_FFFE, 5'd8, 32'd1, 1'b1);         wait_done("rem_7_m2", 1, 34);

    // Divide by zero and signed overflow resolve in one cycle
    start_op(2'b01, 32'h8000_0000, 32'd0, 5'd10, 32'hFFFF_FFFF, 1'b1); wait_done("divu_z", 1, 1);
    start_op(2'b11, 32'h8000_0000, 32'd0, 5'd11, 32'h8000_0000, 1'b1); wait_done("remu_z", 1, 1);
    start_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1'b1); wait_done("div_ovf", 1, 1);
    start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0, 1'b1);         wait_done("rem_ovf", 1, 1);
    start_op(2'b01, 32'hFFFF_FFFF, 32'd1, 5'd14, 32'hFFFF_FFFF, 1'b1);         wait_done("divu_max", 1, 34);

    // Starts while busy are ignored
    start_op(2'b01, 32'd50, 32'd5, 5'd3, 32'd10, 1'b1);
    repeat (3) @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = 2'b00; bus.rs1_data_i = 32'd77; bus.rs2_data_i = 32'd7;
    bus.rd_addr_i = 5'd12;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (14) @(negedge clk);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    wait_done("ign_start", 20, 34);

    // Flush mid-CALC: no pulse, previous result held
    start_op(2'b00, 32'd1000, 32'd3, 5'd9, 32'd333, 1'b0);
    repeat (9) @(negedge clk);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    check("flush_busy", bus.busy_o, 1'b0);
    check("flush_res", bus.result_o, 32'd10);
    check("flush_rd", bus.rd_addr_o, 5'd3);
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done_o) dn++;
    end
    check("flush_no_done", dn, 0);
    check("flush_res_hold", bus.result_o, 32'd10);

    // Flush and start together in IDLE: start dropped
    bus.start_i = 1'b1; bus.flush_i = 1'b1; bus.op_i = 2'b01;
    bus.rs1_data_i = 32'd9; bus.rs2_data_i = 32'd3; bus.rd_addr_i = 5'd20;
    @(negedge clk);
    bus.start_i = 1'b0; bus.flush_i = 1'b0;
    check("fs_busy", bus.busy_o, 1'b0);
    dn = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.done_o || bus.busy_o) dn++;
    end
    check("fs_idle", dn, 0);

    // Reset mid-CALC, then an immediate new operation
    start_op(2'b01, 32'd1234, 32'd5, 5'd4, 32'd246, 1'b0);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_busy", bus.busy_o, 1'b0);
    check("mrst_done", bus.done_o, 1'b0);
    check("mrst_res", bus.result_o, 32'd0);
    check("mrst_rd", bus.rd_addr_o, 5'd0);
    start_op(2'b01, 32'd1234, 32'd5, 5'd4, 32'd246, 1'b1); wait_done("post_rst", 1, 34);

    // Random operations against the reference model
    for (int i = 0; i < 10; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      rexp = ref_div(rop, ra, rb);
      rlat = (rb == 32'd0 || (!rop[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF)) ? 1 : 34;
      start_op(rop, ra, rb, 5'(i + 16), rexp, 1'b1);
      wait_done("rand", 1, rlat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
